elixirchip_es1_spu_op_delay: RTL and testbench



---
 rtl/elixirchip_es1_spu_pkg.sv | 17 +
 rtl/elixirchip_es1_spu_op_delay_lane.sv | 69 ++++++
 rtl/elixirchip_es1_spu_op_delay.sv | 65 ++++++
 tb/tb_elixirchip_es1_spu_op_delay.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU package: HOLD_MODE string constants, lane slicing helper and latency check macro.
package elixirchip_es1_spu_pkg;

  localparam string HOLD_MODE_TRUE  = "true";
  localparam string HOLD_MODE_FALSE = "false";

  // LSB position of lane 'lane' inside a flat bus of 'bits'-wide lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bits);
    return lane * bits;
  endfunction

endpackage

`define ELIXIRCHIP_ES1_SPU_CHECK_LATENCY(lat) \
  if ((lat) < 1) begin : g_bad_latency \
    $error("LATENCY must be >= 1"); \
  end

// File: rtl/elixirchip_es1_spu_op_delay_lane.sv
// Single lane of the SPU delay operator: stage 1 with clear/hold, then a plain shift chain.
module elixirchip_es1_spu_op_delay_lane #(
  parameter int  LATENCY    = 2,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter bit  HOLD       = 1'b1
) (
  input  logic  reset,
  input  logic  clk,
  input  logic  cke,
  input  logic  s_clear,
  input  data_t s_data,
  input  logic  s_valid,
  output data_t m_data,
  output logic  m_valid
);

  `ELIXIRCHIP_ES1_SPU_CHECK_LATENCY(LATENCY)

  data_t s1_data;
  logic  s1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data  <= CLEAR_DATA;
      s1_valid <= 1'b0;
    end else if (cke) begin
      if (s_clear) begin
        s1_data  <= CLEAR_DATA;
        s1_valid <= 1'b1;
      end else if (s_valid) begin
        s1_data  <= s_data;
        s1_valid <= 1'b1;
      end else begin
        s1_valid <= 1'b0;
        if (!HOLD) s1_data <= s_data;
      end
    end
  end

  if (LATENCY > 1) begin : g_chain
    data_t [LATENCY-2:0] chain_data;
    logic  [LATENCY-2:0] chain_valid;
    data_t [LATENCY-1:0] all_data;
    logic  [LATENCY-1:0] all_valid;

    // Stage 1 sits at index 0 so one slice expresses the whole shift.
    assign all_data  = {chain_data, s1_data};
    assign all_valid = {chain_valid, s1_valid};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain_data  <= {(LATENCY-1){CLEAR_DATA}};
        chain_valid <= '0;
      end else if (cke) begin
        chain_data  <= all_data[LATENCY-2:0];
        chain_valid <= all_valid[LATENCY-2:0];
      end
    end

    assign m_data  = all_data[LATENCY-1];
    assign m_valid = all_valid[LATENCY-1];
  end else begin : g_direct
    assign m_data  = s1_data;
    assign m_valid = s1_valid;
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_delay.sv
// Multi-lane SPU delay operator: slices the flat lane buses and instantiates one delay lane per channel.
module elixirchip_es1_spu_op_delay
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    CHANNELS   = 4,
  parameter int    LATENCY    = 2,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter string HOLD_MODE  = "true",
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,
  input  logic [CHANNELS-1:0]           s_clear,
  input  logic [CHANNELS*DATA_BITS-1:0] s_data,
  input  logic [CHANNELS-1:0]           s_valid,
  output logic [CHANNELS*DATA_BITS-1:0] m_data,
  output logic [CHANNELS-1:0]           m_valid
);

  localparam bit HOLD = (HOLD_MODE == HOLD_MODE_TRUE);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be >= 1");
  end
  if (HOLD_MODE != HOLD_MODE_TRUE && HOLD_MODE != HOLD_MODE_FALSE) begin : g_bad_hold
    $error("HOLD_MODE must be \"true\" or \"false\"");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("DEVICE must not be empty");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("DEBUG must be \"true\" or \"false\"");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    elixirchip_es1_spu_op_delay_lane #(
      .LATENCY    (LATENCY),
      .DATA_BITS  (DATA_BITS),
      .data_t     (data_t),
      .CLEAR_DATA (CLEAR_DATA),
      .HOLD       (HOLD)
    ) u_lane (
      .reset   (reset),
      .clk     (clk),
      .cke     (cke),
      .s_clear (s_clear[i]),
      .s_data  (s_data[lane_lsb(i, DATA_BITS) +: DATA_BITS]),
      .s_valid (s_valid[i]),
      .m_data  (m_data[lane_lsb(i, DATA_BITS) +: DATA_BITS]),
      .m_valid (m_valid[i])
    );
  end

  if (SIMULATION == "true") begin : g_sim_checks
    a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
      cke |-> !$isunknown({s_clear, s_valid}))
      else $error("X on s_clear/s_valid while enabled");
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_delay.sv
// Scoreboard bench for elixirchip_es1_spu_op_delay: two configurations driven by shared stimulus.
module tb_elixirchip_es1_spu_op_delay;

  localparam int CH = 4;
  localparam int DB = 8;
  localparam int NDUT = 2;
  // dut 0: LATENCY 3, hold, clear to 0xFF; dut 1: LATENCY 2, no hold, clear to 0x00
  localparam int         LAT  [NDUT] = '{3, 2};
  localparam bit         HOLD [NDUT] = '{1'b1, 1'b0};
  localparam logic [7:0] CLR  [NDUT] = '{8'hFF, 8'h00};

  typedef struct {
    logic [CH*DB-1:0] d;
    logic [CH-1:0]    v;
  } snap_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cke;
  logic [CH-1:0]    s_clear;
  logic [CH*DB-1:0] s_data;
  logic [CH-1:0]    s_valid;
  logic [CH*DB-1:0] m_data  [NDUT];
  logic [CH-1:0]    m_valid [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_delay #(
    .CHANNELS(CH), .LATENCY(3), .DATA_BITS(DB), .CLEAR_DATA(8'hFF),
    .HOLD_MODE("true"), .SIMULATION("true")
  ) dut_hold (
    .reset(reset), .clk(clk), .cke(cke), .s_clear(s_clear), .s_data(s_data),
    .s_valid(s_valid), .m_data(m_data[0]), .m_valid(m_valid[0])
  );

  elixirchip_es1_spu_op_delay #(
    .CHANNELS(CH), .LATENCY(2), .DATA_BITS(DB), .CLEAR_DATA(8'h00),
    .HOLD_MODE("false"), .SIMULATION("true")
  ) dut_nohold (
    .reset(reset), .clk(clk), .cke(cke), .s_clear(s_clear), .s_data(s_data),
    .s_valid(s_valid), .m_data(m_data[1]), .m_valid(m_valid[1])
  );

  // Reference model: per-lane "last accepted value" plus a fixed-length delay line.
  logic [7:0] held [NDUT][CH];
  snap_t      dly_q [NDUT][$];
  snap_t      exp_q [NDUT][$];
  snap_t      last  [NDUT];

  function automatic snap_t reset_snap(input int k);
    snap_t s;
    for (int l = 0; l < CH; l++) s.d[l*DB +: DB] = CLR[k];
    s.v = '0;
    return s;
  endfunction

  function automatic void model_reset(input int k);
    dly_q[k].delete();
    exp_q[k].delete();
    for (int i = 0; i < LAT[k] - 1; i++) dly_q[k].push_back(reset_snap(k));
    for (int l = 0; l < CH; l++) held[k][l] = CLR[k];
    last[k] = reset_snap(k);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NDUT; k++) model_reset(k);
    end else if (cke) begin
      for (int k = 0; k < NDUT; k++) begin
        snap_t s;
        for (int l = 0; l < CH; l++) begin
          logic [7:0] din;
          din = s_data[l*DB +: DB];
          if (s_clear[l])      held[k][l] = CLR[k];
          else if (s_valid[l]) held[k][l] = din;
          else if (!HOLD[k])   held[k][l] = din;
          s.d[l*DB +: DB] = held[k][l];
          s.v[l] = s_clear[l] | s_valid[l];
        end
        dly_q[k].push_back(s);
        exp_q[k].push_back(dly_q[k].pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a fresh expectation appears after every enabled edge; otherwise outputs must stay frozen.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (exp_q[k].size() > 0) last[k] = exp_q[k].pop_front();
      chk($sformatf("sb_data[%0d]", k), m_data[k], last[k].d);
      chk($sformatf("sb_valid[%0d]", k), {28'd0, m_valid[k]}, {28'd0, last[k].v});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane_of(input logic [CH*DB-1:0] vec, input int l);
    return vec[l*DB +: DB];
  endfunction

  initial begin
    reset = 1'b1; cke = 1'b1; s_clear = '0; s_data = '0; s_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Fill every stage with 0xA5, then reset between edges.
    s_valid = '1; s_data = {CH{8'hA5}};
    repeat (4) tick();
    chk("prefill_data", m_data[0], {CH{8'hA5}});
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("async_rst_data[%0d]", k), m_data[k], {CH{CLR[k]}});
      chk($sformatf("async_rst_valid[%0d]", k), {28'd0, m_valid[k]}, 32'd0);
    end
    s_valid = '0; s_data = '0;
    tick();
    reset = 1'b0;
    tick();

    // Single-cycle token on lane 0 appears exactly LATENCY edges later for one cycle.
    s_valid = 4'b0001; s_data = {24'd0, 8'h3C};
    tick();
    s_valid = '0; s_data = '0;
    chk("lat_edge1_valid", {31'd0, m_valid[0][0]}, 32'd0);
    tick();
    chk("lat_edge2_valid", {31'd0, m_valid[0][0]}, 32'd0);
    chk("lat1_out_valid", {31'd0, m_valid[1][0]}, 32'd1);
    tick();
    chk("lat_edge3_valid", {31'd0, m_valid[0][0]}, 32'd1);
    chk("lat_edge3_data", {24'd0, lane_of(m_data[0], 0)}, 32'h3C);
    tick();
    chk("lat_edge4_valid", {31'd0, m_valid[0][0]}, 32'd0);

    // Hold versus load-through on lane 1.
    s_valid = 4'b0010; s_data = {16'd0, 8'h11, 8'd0};
    tick();
    s_valid = '0; s_data = {16'd0, 8'hFF, 8'd0};
    repeat (5) tick();
    chk("hold_data", {24'd0, lane_of(m_data[0], 1)}, 32'h11);
    chk("hold_valid", {31'd0, m_valid[0][1]}, 32'd0);
    chk("nohold_data", {24'd0, lane_of(m_data[1], 1)}, 32'hFF);
    chk("nohold_valid", {31'd0, m_valid[1][1]}, 32'd0);

    // Clear beats valid on lane 2; lane 3 carries an unrelated value.
    s_clear = 4'b0100; s_valid = 4'b1100; s_data = {8'h5A, 8'h77, 16'd0};
    tick();
    s_clear = '0; s_valid = '0;
    tick();
    chk("clear_nohold_data", {24'd0, lane_of(m_data[1], 2)}, 32'h00);
    chk("clear_nohold_valid", {31'd0, m_valid[1][2]}, 32'd1);
    tick();
    chk("clear_hold_data", {24'd0, lane_of(m_data[0], 2)}, 32'hFF);
    chk("clear_hold_valid", {31'd0, m_valid[0][2]}, 32'd1);
    chk("clear_other_lane", {24'd0, lane_of(m_data[0], 3)}, 32'h5A);

    // Random traffic with occasional clock-enable drops and one mid-run reset.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      cke = ($urandom_range(0, 9) != 0);
      for (int l = 0; l < CH; l++) begin
        s_clear[l] = ($urandom_range(0, 19) == 0);
        s_valid[l] = $urandom_range(0, 1) != 0;
      end
      s_data = $urandom;
      if (cyc == 5000) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    cke = 1'b1; s_clear = '0; s_valid = '0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
